// File: rtl/prog_rom_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_rom_if
// Description : Load and fetch signal bundle for prog_rom. The master side
//               drives the load stream and fetch requests. The slave side
//               (the ROM) returns load flow control and fetched fields.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_rom_if #(
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4,
    parameter int IMM_W  = 4
);
    logic                     ld_start;
    logic                     ld_valid;
    logic [OPC_W+IMM_W-1:0]   ld_data;
    logic                     ld_last;
    logic                     ld_ready;
    logic                     loaded;
    logic                     rd_req;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     rd_valid;
    logic                     rd_err;
    logic [OPC_W-1:0]         out_opcode;
    logic [IMM_W-1:0]         out_imdata;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, rd_req, rd_addr,
        input  ld_ready, loaded, rd_valid, rd_err, out_opcode, out_imdata
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, rd_req, rd_addr,
        output ld_ready, loaded, rd_valid, rd_err, out_opcode, out_imdata
    );
endinterface
`default_nettype wire

// File: rtl/prog_rom.sv
`default_nettype none
// ============================================================================
// Module      : prog_rom
// Description : Loadable program store. A program is streamed in from
//               address 0 and ends on ld_last or at the top address. It is
//               then fetched with a one-cycle latency. Any word the last load
//               did not write reads back as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_rom #(
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4,
    parameter int IMM_W  = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    prog_rom_if.slave   bus
);
    localparam int                c_word_w    = OPC_W + IMM_W;
    localparam int                c_depth     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_ptr;
    logic [c_depth-1:0]    r_written;
    logic                  r_loaded;
    logic                  r_ld_ready;
    logic                  r_rd_valid;
    logic                  r_rd_err;
    logic [OPC_W-1:0]      r_opcode;
    logic [IMM_W-1:0]      r_imdata;
    logic [c_word_w-1:0]   r_mem [c_depth];

    logic                  w_xfer;
    logic [c_word_w-1:0]   w_rd_word;

    // A word is accepted only in LOAD. A restart pulse in the same cycle wins
    // over the word.
    assign w_xfer = (r_state == S_LOAD) && bus.ld_valid && !bus.ld_start;

    // Words not written since the last load entry are masked to zero.
    assign w_rd_word = r_written[bus.rd_addr] ? r_mem[bus.rd_addr] : '0;

    assign bus.ld_ready   = r_ld_ready;
    assign bus.loaded     = r_loaded;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_err     = r_rd_err;
    assign bus.out_opcode = r_opcode;
    assign bus.out_imdata = r_imdata;

    // Storage array. It has no reset because the written-flag vector decides
    // what reads return.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[r_ptr] <= bus.ld_data;
        end
    end

    // Load/fetch control FSM. Every status and data output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_ptr      <= '0;
            r_written  <= '0;
            r_loaded   <= 1'b0;
            r_ld_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_opcode   <= '0;
            r_imdata   <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;

            // A fetch is serviced from the current contents, even when a
            // reload starts in the same cycle.
            if (bus.rd_req) begin
                if (r_state == S_READY) begin
                    r_rd_valid <= 1'b1;
                    r_opcode   <= w_rd_word[c_word_w-1:IMM_W];
                    r_imdata   <= w_rd_word[IMM_W-1:0];
                end else begin
                    r_rd_err   <= 1'b1;
                end
            end

            case (r_state)
                S_EMPTY: begin
                    if (bus.ld_start) begin
                        r_state    <= S_LOAD;
                        r_ptr      <= '0;
                        r_written  <= '0;
                        r_ld_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.ld_start) begin
                        r_ptr     <= '0;
                        r_written <= '0;
                    end else if (bus.ld_valid) begin
                        r_written[r_ptr] <= 1'b1;
                        // The top address ends the load even without ld_last,
                        // so the pointer never wraps.
                        if (bus.ld_last || (r_ptr == c_last_addr)) begin
                            r_state    <= S_READY;
                            r_ld_ready <= 1'b0;
                            r_loaded   <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (bus.ld_start) begin
                        r_state    <= S_LOAD;
                        r_ptr      <= '0;
                        r_written  <= '0;
                        r_loaded   <= 1'b0;
                        r_ld_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_loaded   <= 1'b0;
                    r_ld_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_prog_rom.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_rom
// Description : Directed, self-checking bench for prog_rom. Default-size and
//               wide-word instances are driven from one stimulus sequence.
//               Fetch results are predicted into a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_rom;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_rom_if #(.ADDR_W(4), .OPC_W(4), .IMM_W(4)) ifa ();
    prog_rom_if #(.ADDR_W(6), .OPC_W(8), .IMM_W(8)) ifb ();

    prog_rom #(.ADDR_W(4), .OPC_W(4), .IMM_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    prog_rom #(.ADDR_W(6), .OPC_W(8), .IMM_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        logic       err;
        logic [3:0] opc;
        logic [3:0] imm;
    } exp_t;

    exp_t       sbq[$];
    int         vectors     = 0;
    int         miscompares = 0;

    // Reference model of the default instance
    logic [7:0] m_mem  [16];
    bit         m_flag [16];
    bit         m_ready = 1'b0;
    logic [3:0] m_opc   = '0;
    logic [3:0] m_imm   = '0;
    logic [7:0] ld_buf [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) m_flag[i] = 1'b0;
    endtask

    // Compare the default instance's fetch outputs with the scoreboard
    task automatic check_a();
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("rd_valid", ifa.rd_valid, !e.err);
            chk("rd_err", ifa.rd_err, e.err);
            chk("out_opcode", ifa.out_opcode, e.opc);
            chk("out_imdata", ifa.out_imdata, e.imm);
        end else begin
            chk("idle_pulses", {ifa.rd_valid, ifa.rd_err}, 2'b00);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_a();
    endtask

    // Drive a fetch request and predict its result
    task automatic push_fetch(input int addr);
        exp_t       e;
        logic [7:0] w;
        ifa.rd_req  = 1'b1;
        ifa.rd_addr = 4'(addr);
        if (m_ready) begin
            w     = m_flag[addr] ? m_mem[addr] : 8'h00;
            m_opc = w[7:4];
            m_imm = w[3:0];
            e.err = 1'b0;
        end else begin
            e.err = 1'b1;
        end
        e.opc = m_opc;
        e.imm = m_imm;
        sbq.push_back(e);
    endtask

    task automatic a_fetch(input int addr);
        push_fetch(addr);
        tick();
    endtask

    task automatic a_load(input int n, input bit use_last, input bit gap);
        bit done;
        done = use_last || (n == 16);
        ifa.ld_start = 1'b1;
        tick();
        ifa.ld_start = 1'b0;
        clear_model();
        chk("ld_ready_on_start", ifa.ld_ready, 1'b1);
        chk("loaded_on_start", ifa.loaded, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                ifa.ld_valid = 1'b0;
                ifa.ld_data  = 8'hEE;
                tick();
            end
            ifa.ld_valid = 1'b1;
            ifa.ld_data  = ld_buf[i];
            ifa.ld_last  = use_last && (i == n - 1);
            tick();
            m_mem[i]  = ld_buf[i];
            m_flag[i] = 1'b1;
            chk("loaded_during_load", ifa.loaded, done && (i == n - 1));
        end
        ifa.ld_valid = 1'b0;
        ifa.ld_last  = 1'b0;
        m_ready      = done;
        chk("ld_ready_after_load", ifa.ld_ready, !done);
    endtask

    function automatic logic [15:0] wb(input int i);
        return {8'(i * 3 + 1), 8'(255 - i)};
    endfunction

    initial begin
        {ifa.ld_start, ifa.ld_valid, ifa.ld_last, ifa.rd_req} = '0;
        ifa.ld_data = '0;
        ifa.rd_addr = '0;
        {ifb.ld_start, ifb.ld_valid, ifb.ld_last, ifb.rd_req} = '0;
        ifb.ld_data = '0;
        ifb.rd_addr = '0;
        clear_model();

        // Reset state
        #1;
        chk("rst_loaded", ifa.loaded, 1'b0);
        chk("rst_ld_ready", ifa.ld_ready, 1'b0);
        chk("rst_outputs", {ifa.rd_valid, ifa.rd_err, ifa.out_opcode, ifa.out_imdata}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Load words in EMPTY are ignored
        ifa.ld_valid = 1'b1;
        ifa.ld_data  = 8'h77;
        tick();
        tick();
        ifa.ld_valid = 1'b0;
        chk("empty_ld_ready", ifa.ld_ready, 1'b0);

        // Fetch before any load is rejected
        a_fetch(3);
        ifa.rd_req = 1'b0;
        tick();

        // Full 16-word load with implicit last, then back-to-back fetch
        for (int i = 0; i < 16; i++) ld_buf[i] = 8'((i << 4) | (15 - i));
        a_load(16, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) a_fetch(i);
        ifa.rd_req = 1'b0;
        tick();

        // Short load ended by ld_last; the tail reads zero
        ld_buf[0] = 8'hA1; ld_buf[1] = 8'hB2; ld_buf[2] = 8'hC3;
        a_load(3, 1'b1, 1'b0);
        a_fetch(2);
        a_fetch(3);
        a_fetch(0);
        ifa.rd_req = 1'b0;
        tick();

        // Gapped load
        ld_buf[0] = 8'h12; ld_buf[1] = 8'h34; ld_buf[2] = 8'h56; ld_buf[3] = 8'h78;
        a_load(4, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) a_fetch(i);
        ifa.rd_req = 1'b0;
        tick();
        a_fetch(1);
        ifa.rd_req = 1'b0;

        // Fetch and reload in the same cycle: the old contents are returned
        ifa.ld_start = 1'b1;
        push_fetch(3);
        tick();
        ifa.ld_start = 1'b0;
        ifa.rd_req   = 1'b0;
        clear_model();
        chk("reload_ld_ready", ifa.ld_ready, 1'b1);
        chk("reload_loaded", ifa.loaded, 1'b0);

        // Fetch during LOAD is rejected and the data outputs hold
        a_fetch(0);
        ifa.rd_req = 1'b0;

        // Restart inside LOAD, partial load, then an async reset mid-load
        for (int i = 0; i < 16; i++) ld_buf[i] = 8'((i << 4) | (15 - i));
        a_load(5, 1'b0, 1'b0);
        a_fetch(2);
        ifa.rd_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        m_opc = '0;
        m_imm = '0;
        chk("async_rst_status", {ifa.loaded, ifa.ld_ready, ifa.rd_valid, ifa.rd_err}, 4'b0000);
        chk("async_rst_data", {ifa.out_opcode, ifa.out_imdata}, 8'h00);
        tick();
        rst = 1'b0;
        a_fetch(4);
        ifa.rd_req = 1'b0;
        for (int i = 0; i < 16; i++) ld_buf[i] = 8'(i * 7 + 3);
        a_load(16, 1'b0, 1'b0);
        a_fetch(4);
        for (int i = 0; i < 16; i++) a_fetch(i);
        ifa.rd_req = 1'b0;
        tick();

        // Wide instance: 64 words, implicit last at address 63
        ifb.ld_start = 1'b1;
        tick();
        ifb.ld_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ifb.ld_valid = 1'b1;
            ifb.ld_data  = wb(i);
            tick();
            if (i == 62) chk("b_loaded_early", ifb.loaded, 1'b0);
        end
        ifb.ld_valid = 1'b0;
        chk("b_loaded", ifb.loaded, 1'b1);
        chk("b_ld_ready", ifb.ld_ready, 1'b0);
        ifb.rd_req  = 1'b1;
        ifb.rd_addr = 6'd63;
        tick();
        chk("b_rd_valid_63", ifb.rd_valid, 1'b1);
        chk("b_word_63", {ifb.out_opcode, ifb.out_imdata}, wb(63));
        ifb.rd_addr = 6'd0;
        tick();
        ifb.rd_req = 1'b0;
        chk("b_rd_valid_0", ifb.rd_valid, 1'b1);
        chk("b_word_0", {ifb.out_opcode, ifb.out_imdata}, wb(0));
        tick();
        chk("b_idle", {ifb.rd_valid, ifb.rd_err}, 2'b00);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
